// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl
// Commit sequencer between the WB stage and the CSR file. For each valid WB
// instruction the controller decides (in the same cycle) whether it retires
// normally, raises an exception, takes a pending interrupt or executes ertn.
// Exceptions, interrupts and ertn flush the pipeline, hand a redirect PC to
// fetch and hold further commits off until the redirect has been accepted
// and the flush has drained.
module exc_commit_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [5:0]  ECODE_INT    = 6'h0,
  parameter logic [31:0] EX_CNT_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_ex_in,
  input  logic [5:0]  wb_ecode_in,
  input  logic [8:0]  wb_esubcode_in,
  input  logic [31:0] wb_vaddr_in,
  input  logic        wb_ertn,
  input  logic [12:0] csr_is,
  input  logic [12:0] csr_lie,
  input  logic        csr_ie,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        wb_commit,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_ex_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic [31:0] ex_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_e;

  // A zero drain length skips the DRAIN state entirely.
  localparam logic       DRAIN_EN   = (DRAIN_CYCLES != 32'd0);
  localparam logic [3:0] DRAIN_LOAD = DRAIN_EN ? 4'(DRAIN_CYCLES - 32'd1) : 4'h0;

  // Saturating increment: the exception counter never wraps back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    if (value == 32'hffff_ffff) begin
      sat_inc = value;
    end else begin
      sat_inc = value + 32'd1;
    end
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic [31:0] ex_cnt_q, ex_cnt_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic int_req_s;
  logic take_int_s;
  logic take_exc_s;
  logic take_ertn_s;
  logic take_ret_s;
  logic take_trap_s;
  logic take_flush_s;

  // Classify the WB instruction: interrupt beats exception beats ertn beats retire.
  always_comb begin
    int_req_s   = csr_ie & (|(csr_is & csr_lie));
    take_int_s  = 1'b0;
    take_exc_s  = 1'b0;
    take_ertn_s = 1'b0;
    take_ret_s  = 1'b0;
    if (resetn && (state_q == ST_IDLE) && wb_valid) begin
      if (int_req_s) begin
        take_int_s = 1'b1;
      end else if (wb_ex_in) begin
        take_exc_s = 1'b1;
      end else if (wb_ertn) begin
        take_ertn_s = 1'b1;
      end else begin
        take_ret_s = 1'b1;
      end
    end else begin
      take_ret_s = 1'b0;
    end
    take_trap_s  = take_int_s | take_exc_s;
    take_flush_s = take_trap_s | take_ertn_s;
  end

  // Same-cycle pulses to the CSR file and pipeline; trap payload is zero unless a trap fires.
  always_comb begin
    wb_commit   = take_ertn_s | take_ret_s;
    wb_ex       = take_trap_s;
    ertn_flush  = take_ertn_s;
    pipe_flush  = take_flush_s;
    wb_ecode    = 6'h0;
    wb_esubcode = 9'h0;
    wb_ex_pc    = 32'h0;
    wb_vaddr    = 32'h0;
    if (take_int_s) begin
      wb_ecode    = ECODE_INT;
      wb_esubcode = 9'h0;
      wb_ex_pc    = wb_pc;
      wb_vaddr    = 32'h0;
    end else if (take_exc_s) begin
      wb_ecode    = wb_ecode_in;
      wb_esubcode = wb_esubcode_in;
      wb_ex_pc    = wb_pc;
      wb_vaddr    = wb_vaddr_in;
    end else begin
      wb_ecode    = 6'h0;
    end
  end

  // Next-state logic for the redirect/drain sequencer and its bookkeeping registers.
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    ex_cnt_d      = ex_cnt_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (take_flush_s) begin
          state_d = ST_REDIRECT;
          if (take_trap_s) begin
            redirect_pc_d = csr_eentry;
            ex_cnt_d      = sat_inc(ex_cnt_q);
          end else begin
            redirect_pc_d = csr_era;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          if (DRAIN_EN) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_REDIRECT;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        drain_cnt_d = 4'd0;
      end
    endcase
  end

  // State and bookkeeping registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      drain_cnt_q   <= 4'd0;
      ex_cnt_q      <= EX_CNT_RESET;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      ex_cnt_q      <= ex_cnt_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign ex_cnt         = ex_cnt_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed testbench for exc_commit_ctrl. u_dut uses DRAIN_CYCLES=2; u_sat
// shares every input, uses DRAIN_CYCLES=0 and starts its counter at
// 32'hfffffffe so saturation is reachable in two traps.
module tb_exc_commit_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_ex_in;
  logic [5:0]  wb_ecode_in;
  logic [8:0]  wb_esubcode_in;
  logic [31:0] wb_vaddr_in;
  logic        wb_ertn;
  logic [12:0] csr_is;
  logic [12:0] csr_lie;
  logic        csr_ie;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        redirect_ready;

  logic        wb_commit, wb_ex, ertn_flush, pipe_flush, redirect_valid;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_ex_pc, wb_vaddr, redirect_pc, ex_cnt;

  logic        s_wb_commit, s_wb_ex, s_ertn_flush, s_pipe_flush, s_redirect_valid;
  logic [5:0]  s_wb_ecode;
  logic [8:0]  s_wb_esubcode;
  logic [31:0] s_wb_ex_pc, s_wb_vaddr, s_redirect_pc, s_ex_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exc_commit_ctrl #(.DRAIN_CYCLES(2), .ECODE_INT(6'h0)) u_dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_ex_in(wb_ex_in), .wb_ecode_in(wb_ecode_in), .wb_esubcode_in(wb_esubcode_in),
    .wb_vaddr_in(wb_vaddr_in), .wb_ertn(wb_ertn), .csr_is(csr_is), .csr_lie(csr_lie),
    .csr_ie(csr_ie), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .wb_commit(wb_commit), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_ex_pc(wb_ex_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
    .pipe_flush(pipe_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .ex_cnt(ex_cnt)
  );

  exc_commit_ctrl #(.DRAIN_CYCLES(0), .ECODE_INT(6'h0), .EX_CNT_RESET(32'hfffffffe)) u_sat (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_ex_in(wb_ex_in), .wb_ecode_in(wb_ecode_in), .wb_esubcode_in(wb_esubcode_in),
    .wb_vaddr_in(wb_vaddr_in), .wb_ertn(wb_ertn), .csr_is(csr_is), .csr_lie(csr_lie),
    .csr_ie(csr_ie), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .wb_commit(s_wb_commit), .wb_ex(s_wb_ex), .wb_ecode(s_wb_ecode),
    .wb_esubcode(s_wb_esubcode), .wb_ex_pc(s_wb_ex_pc), .wb_vaddr(s_wb_vaddr),
    .ertn_flush(s_ertn_flush), .pipe_flush(s_pipe_flush),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .redirect_ready(redirect_ready), .ex_cnt(s_ex_cnt)
  );

  // Move to just after the next rising edge, where inputs are changed.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    wb_valid       = 1'b0;
    wb_pc          = 32'h0;
    wb_ex_in       = 1'b0;
    wb_ecode_in    = 6'h0;
    wb_esubcode_in = 9'h0;
    wb_vaddr_in    = 32'h0;
    wb_ertn        = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    redirect_ready = 1'b0;
    csr_is = 13'h0; csr_lie = 13'h0; csr_ie = 1'b0;
    csr_eentry = 32'h1c008000; csr_era = 32'h1c000500;
    clear_wb();
    repeat (2) cyc();
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL rst_redirect_valid got=%0h exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_redirect_pc got=%0h exp=0", redirect_pc); end
    checks++; if (ex_cnt !== 32'h0) begin failures++; $display("FAIL rst_ex_cnt got=%0h exp=0", ex_cnt); end
    checks++; if (s_ex_cnt !== 32'hfffffffe) begin failures++; $display("FAIL rst_sat_ex_cnt got=%0h exp=fffffffe", s_ex_cnt); end
    checks++; if (wb_commit !== 1'b0) begin failures++; $display("FAIL rst_commit got=%0h exp=0", wb_commit); end
    cyc();
    resetn = 1'b1;
  endtask

  task automatic test_retire();
    cyc();
    wb_valid = 1'b1; wb_pc = 32'h1c000100;
    @(negedge clk);
    checks++; if (wb_commit !== 1'b1) begin failures++; $display("FAIL retire_commit got=%0h exp=1", wb_commit); end
    checks++; if (pipe_flush !== 1'b0) begin failures++; $display("FAIL retire_flush got=%0h exp=0", pipe_flush); end
    checks++; if (wb_ex !== 1'b0) begin failures++; $display("FAIL retire_wb_ex got=%0h exp=0", wb_ex); end
    cyc();
    clear_wb();
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL retire_stay_idle got=%0h exp=0", redirect_valid); end
    checks++; if (wb_commit !== 1'b0) begin failures++; $display("FAIL retire_no_valid_commit got=%0h exp=0", wb_commit); end
  endtask

  task automatic test_exception();
    cyc();
    wb_valid = 1'b1; wb_pc = 32'h1c000200; wb_ex_in = 1'b1;
    wb_ecode_in = 6'h9; wb_esubcode_in = 9'h1; wb_vaddr_in = 32'h1003;
    @(negedge clk);
    checks++; if (wb_ex !== 1'b1) begin failures++; $display("FAIL exc_wb_ex got=%0h exp=1", wb_ex); end
    checks++; if (wb_ecode !== 6'h9) begin failures++; $display("FAIL exc_ecode got=%0h exp=9", wb_ecode); end
    checks++; if (wb_esubcode !== 9'h1) begin failures++; $display("FAIL exc_esub got=%0h exp=1", wb_esubcode); end
    checks++; if (wb_vaddr !== 32'h1003) begin failures++; $display("FAIL exc_vaddr got=%0h exp=1003", wb_vaddr); end
    checks++; if (wb_ex_pc !== 32'h1c000200) begin failures++; $display("FAIL exc_ex_pc got=%0h exp=1c000200", wb_ex_pc); end
    checks++; if (wb_commit !== 1'b0) begin failures++; $display("FAIL exc_commit got=%0h exp=0", wb_commit); end
    checks++; if (pipe_flush !== 1'b1) begin failures++; $display("FAIL exc_flush got=%0h exp=1", pipe_flush); end
    checks++; if (ertn_flush !== 1'b0) begin failures++; $display("FAIL exc_ertn got=%0h exp=0", ertn_flush); end
    cyc();
    wb_valid = 1'b0; redirect_ready = 1'b1;
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL exc_redirect_valid got=%0h exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h1c008000) begin failures++; $display("FAIL exc_redirect_pc got=%0h exp=1c008000", redirect_pc); end
    checks++; if (ex_cnt !== 32'h1) begin failures++; $display("FAIL exc_ex_cnt got=%0h exp=1", ex_cnt); end
    checks++; if (wb_ex !== 1'b0) begin failures++; $display("FAIL exc_pulse_len got=%0h exp=0", wb_ex); end
    checks++; if (wb_ecode !== 6'h0) begin failures++; $display("FAIL exc_ecode_zero got=%0h exp=0", wb_ecode); end
    cyc();
    wb_valid = 1'b1; wb_ex_in = 1'b0; wb_pc = 32'h1c000204;
    @(negedge clk);
    checks++; if (wb_commit !== 1'b0) begin failures++; $display("FAIL exc_drain1_commit got=%0h exp=0", wb_commit); end
    cyc();
    @(negedge clk);
    checks++; if (wb_commit !== 1'b0) begin failures++; $display("FAIL exc_drain2_commit got=%0h exp=0", wb_commit); end
    cyc();
    @(negedge clk);
    checks++; if (wb_commit !== 1'b1) begin failures++; $display("FAIL exc_first_commit got=%0h exp=1", wb_commit); end
    checks++; if (pipe_flush !== 1'b0) begin failures++; $display("FAIL exc_first_commit_flush got=%0h exp=0", pipe_flush); end
    cyc();
    clear_wb(); redirect_ready = 1'b0;
  endtask

  task automatic test_int_over_ertn();
    cyc();
    wb_valid = 1'b1; wb_pc = 32'h1c000400; wb_ertn = 1'b1; wb_ex_in = 1'b1;
    wb_ecode_in = 6'h9; wb_esubcode_in = 9'h1; wb_vaddr_in = 32'h1003;
    csr_is = 13'h800; csr_lie = 13'h800; csr_ie = 1'b1;
    @(negedge clk);
    checks++; if (wb_ex !== 1'b1) begin failures++; $display("FAIL int_wb_ex got=%0h exp=1", wb_ex); end
    checks++; if (wb_ecode !== 6'h0) begin failures++; $display("FAIL int_ecode got=%0h exp=0", wb_ecode); end
    checks++; if (wb_esubcode !== 9'h0) begin failures++; $display("FAIL int_esub got=%0h exp=0", wb_esubcode); end
    checks++; if (ertn_flush !== 1'b0) begin failures++; $display("FAIL int_ertn got=%0h exp=0", ertn_flush); end
    checks++; if (wb_commit !== 1'b0) begin failures++; $display("FAIL int_commit got=%0h exp=0", wb_commit); end
    checks++; if (pipe_flush !== 1'b1) begin failures++; $display("FAIL int_flush got=%0h exp=1", pipe_flush); end
    checks++; if (wb_ex_pc !== 32'h1c000400) begin failures++; $display("FAIL int_ex_pc got=%0h exp=1c000400", wb_ex_pc); end
    cyc();
    wb_valid = 1'b0; redirect_ready = 1'b1;
    @(negedge clk);
    checks++; if (redirect_pc !== 32'h1c008000) begin failures++; $display("FAIL int_redirect_pc got=%0h exp=1c008000", redirect_pc); end
    checks++; if (ex_cnt !== 32'h2) begin failures++; $display("FAIL int_ex_cnt got=%0h exp=2", ex_cnt); end
    repeat (3) cyc();
    wb_valid = 1'b1; wb_ex_in = 1'b0; csr_ie = 1'b0; wb_pc = 32'h1c000404;
    @(negedge clk);
    checks++; if (ertn_flush !== 1'b1) begin failures++; $display("FAIL ertn_flush got=%0h exp=1", ertn_flush); end
    checks++; if (wb_ex !== 1'b0) begin failures++; $display("FAIL ertn_wb_ex got=%0h exp=0", wb_ex); end
    checks++; if (wb_commit !== 1'b1) begin failures++; $display("FAIL ertn_commit got=%0h exp=1", wb_commit); end
    checks++; if (pipe_flush !== 1'b1) begin failures++; $display("FAIL ertn_pipe_flush got=%0h exp=1", pipe_flush); end
    checks++; if (wb_ecode !== 6'h0) begin failures++; $display("FAIL ertn_ecode got=%0h exp=0", wb_ecode); end
    cyc();
    wb_valid = 1'b0;
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL ertn_redirect_valid got=%0h exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h1c000500) begin failures++; $display("FAIL ertn_redirect_pc got=%0h exp=1c000500", redirect_pc); end
    checks++; if (ex_cnt !== 32'h2) begin failures++; $display("FAIL ertn_ex_cnt got=%0h exp=2", ex_cnt); end
    cyc();
    clear_wb(); csr_is = 13'h0; csr_lie = 13'h0; redirect_ready = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_backpressure();
    wb_valid = 1'b1; wb_pc = 32'h1c000600; wb_ex_in = 1'b1; wb_ecode_in = 6'h9;
    @(negedge clk);
    checks++; if (wb_ex !== 1'b1) begin failures++; $display("FAIL bp_event got=%0h exp=1", wb_ex); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 2) csr_eentry = 32'h1c009000;
      @(negedge clk);
      checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_%0d got=%0h exp=1", i, redirect_valid); end
      checks++; if (redirect_pc !== 32'h1c008000) begin failures++; $display("FAIL bp_pc_%0d got=%0h exp=1c008000", i, redirect_pc); end
      checks++; if (wb_commit !== 1'b0 || wb_ex !== 1'b0 || pipe_flush !== 1'b0) begin failures++; $display("FAIL bp_pulses_%0d got=%0h%0h%0h exp=000", i, wb_commit, wb_ex, pipe_flush); end
      checks++; if (ex_cnt !== 32'h3) begin failures++; $display("FAIL bp_ex_cnt_%0d got=%0h exp=3", i, ex_cnt); end
    end
    cyc();
    redirect_ready = 1'b1; wb_ex_in = 1'b0;
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL bp_hs_valid got=%0h exp=1", redirect_valid); end
    checks++; if (wb_commit !== 1'b0) begin failures++; $display("FAIL bp_hs_commit got=%0h exp=0", wb_commit); end
    cyc();
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_valid got=%0h exp=0", redirect_valid); end
    checks++; if (wb_commit !== 1'b0) begin failures++; $display("FAIL bp_drain1_commit got=%0h exp=0", wb_commit); end
    cyc();
    @(negedge clk);
    checks++; if (wb_commit !== 1'b0) begin failures++; $display("FAIL bp_drain2_commit got=%0h exp=0", wb_commit); end
    cyc();
    @(negedge clk);
    checks++; if (wb_commit !== 1'b1) begin failures++; $display("FAIL bp_first_commit got=%0h exp=1", wb_commit); end
    cyc();
    clear_wb(); redirect_ready = 1'b0; csr_eentry = 32'h1c008000;
  endtask

  task automatic test_reset_mid();
    cyc();
    wb_valid = 1'b1; wb_pc = 32'h1c000700; wb_ex_in = 1'b1; wb_ecode_in = 6'h9;
    cyc();
    clear_wb();
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid got=%0h exp=1", redirect_valid); end
    cyc();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1; wb_valid = 1'b1; wb_pc = 32'h1c000800;
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0h exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL rmid_pc got=%0h exp=0", redirect_pc); end
    checks++; if (ex_cnt !== 32'h0) begin failures++; $display("FAIL rmid_ex_cnt got=%0h exp=0", ex_cnt); end
    checks++; if (wb_commit !== 1'b1) begin failures++; $display("FAIL rmid_idle_commit got=%0h exp=1", wb_commit); end
    checks++; if (s_ex_cnt !== 32'hfffffffe) begin failures++; $display("FAIL rmid_sat_ex_cnt got=%0h exp=fffffffe", s_ex_cnt); end
    cyc();
    clear_wb();
  endtask

  task automatic test_saturation();
    cyc();
    wb_valid = 1'b1; wb_pc = 32'h1c000900; wb_ex_in = 1'b1; wb_ecode_in = 6'h9;
    redirect_ready = 1'b1;
    cyc();
    wb_valid = 1'b0;
    @(negedge clk);
    checks++; if (s_ex_cnt !== 32'hffffffff) begin failures++; $display("FAIL sat_first got=%0h exp=ffffffff", s_ex_cnt); end
    checks++; if (ex_cnt !== 32'h1) begin failures++; $display("FAIL sat_main_first got=%0h exp=1", ex_cnt); end
    cyc();
    wb_valid = 1'b1; wb_ex_in = 1'b0;
    @(negedge clk);
    checks++; if (s_wb_commit !== 1'b1) begin failures++; $display("FAIL sat_nodrain_commit got=%0h exp=1", s_wb_commit); end
    checks++; if (wb_commit !== 1'b0) begin failures++; $display("FAIL sat_main_drain_commit got=%0h exp=0", wb_commit); end
    cyc();
    wb_valid = 1'b0;
    cyc();
    wb_valid = 1'b1; wb_ex_in = 1'b1;
    @(negedge clk);
    checks++; if (wb_ex !== 1'b1 || s_wb_ex !== 1'b1) begin failures++; $display("FAIL sat_second_event got=%0h%0h exp=11", wb_ex, s_wb_ex); end
    cyc();
    wb_valid = 1'b0;
    @(negedge clk);
    checks++; if (s_ex_cnt !== 32'hffffffff) begin failures++; $display("FAIL sat_hold got=%0h exp=ffffffff", s_ex_cnt); end
    checks++; if (ex_cnt !== 32'h2) begin failures++; $display("FAIL sat_main_second got=%0h exp=2", ex_cnt); end
    clear_wb();
    repeat (4) cyc();
  endtask

  initial begin
    test_reset();
    test_retire();
    test_exception();
    test_int_over_ertn();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
